// File: rtl/ysyx_22041412_gpr_mp_if.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22041412_gpr_mp_if
//  Brief    : Bus bundle of the multi-port GPR file. Decode drives the read
//             addresses and allocation, writeback drives the result ports,
//             and the register file returns read data, busy flags and the
//             busy count.
//  Revision : 1.0 - initial release
// ============================================================================
interface ysyx_22041412_gpr_mp_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic                flush;
  logic [AW:0]         busy_cnt;

  // Pipeline side: issues reads, allocations, writebacks and flushes
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    input  rd_data, rd_busy, busy_cnt
  );

  // Register-file side
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    output rd_data, rd_busy, busy_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_22041412_gpr_mp.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22041412_gpr_mp
//  Brief    : Multi-port general-purpose register file with a per-register
//             busy scoreboard. NRD combinational read ports, NWR writeback
//             ports (highest index wins on a collision), optional same-cycle
//             write-to-read bypass, x0 hard-wired to zero, and a registered
//             count of busy registers.
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_22041412_gpr_mp #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  wire logic              clk,
  input  wire logic              rst,
  ysyx_22041412_gpr_mp_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [AW:0]     busy_cnt_q;
  logic [AW:0]     busy_cnt_d;

  // --------------------------------------------------------------------------
  // Unpacked views of the flattened writeback ports
  // --------------------------------------------------------------------------
  logic [AW-1:0]   wr_addr_w [NWR];
  logic [XLEN-1:0] wr_data_w [NWR];
  logic [NWR-1:0]  wr_live_w;

  for (genvar j = 0; j < NWR; j++) begin : g_wr_unpack
    assign wr_addr_w[j] = bus.wr_addr[j*AW +: AW];
    assign wr_data_w[j] = bus.wr_data[j*XLEN +: XLEN];
    // A write to x0 is dropped entirely, so it never counts as live
    assign wr_live_w[j] = bus.wr_en[j] && (wr_addr_w[j] != '0);
  end

  // --------------------------------------------------------------------------
  // Array next state: walk ports low to high so the highest port lands last
  // --------------------------------------------------------------------------
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_live_w[j]) begin
        regs_d[wr_addr_w[j]] = wr_data_w[j];
      end
    end
    regs_d[0] = '0;
  end

  // --------------------------------------------------------------------------
  // Scoreboard next state: writeback clears, allocation sets, flush clears all
  // --------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    // Lowest priority: a completing writeback retires the producer
    for (int j = 0; j < NWR; j++) begin
      if (wr_live_w[j]) begin
        busy_d[wr_addr_w[j]] = 1'b0;
      end
    end
    // A new producer allocated this cycle supersedes the old writeback
    if (bus.alloc_en) begin
      busy_d[bus.alloc_addr] = 1'b1;
    end
    // Flush discards every outstanding producer, including this cycle's
    if (bus.flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Popcount of the next busy vector so busy_cnt tracks busy bits with no lag
  // --------------------------------------------------------------------------
  always_comb begin
    busy_cnt_d = '0;
    for (int r = 0; r < NREG; r++) begin
      busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[r]};
    end
  end

  // --------------------------------------------------------------------------
  // State registers with asynchronous clear
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign bus.busy_cnt = busy_cnt_q;

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra_w;
    logic [XLEN-1:0] data_w;
    logic            busy_w;
    logic            hit_w;

    assign ra_w = bus.rd_addr[i*AW +: AW];

    // Stored value, optionally overridden by the highest matching writeback;
    // x0 and the reset state always read as zero / not busy
    always_comb begin
      data_w = regs_q[ra_w];
      busy_w = busy_q[ra_w];
      hit_w  = 1'b0;
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_live_w[j] && (wr_addr_w[j] == ra_w)) begin
            data_w = wr_data_w[j];
            hit_w  = 1'b1;
          end
        end
      end
      // A forwarded value is ready unless a new producer claims it right now
      if (hit_w) begin
        busy_w = bus.alloc_en && (bus.alloc_addr == ra_w);
      end
      if ((ra_w == '0) || rst) begin
        data_w = '0;
        busy_w = 1'b0;
      end
    end

    assign bus.rd_data[i*XLEN +: XLEN] = data_w;
    assign bus.rd_busy[i]              = busy_w;
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041412_gpr_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_22041412_gpr_mp
//  Brief    : Self-checking bench for the multi-port GPR file. Two copies of
//             the design (bypass on / bypass off) share one stimulus stream
//             and are compared against a behavioural array-plus-scoreboard
//             model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22041412_gpr_mp;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NRD*AW-1:0]   rd_addr;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic                flush;

  ysyx_22041412_gpr_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus_b ();
  ysyx_22041412_gpr_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus_n ();

  assign bus_b.rd_addr = rd_addr;    assign bus_n.rd_addr = rd_addr;
  assign bus_b.wr_en = wr_en;        assign bus_n.wr_en = wr_en;
  assign bus_b.wr_addr = wr_addr;    assign bus_n.wr_addr = wr_addr;
  assign bus_b.wr_data = wr_data;    assign bus_n.wr_data = wr_data;
  assign bus_b.alloc_en = alloc_en;  assign bus_n.alloc_en = alloc_en;
  assign bus_b.alloc_addr = alloc_addr; assign bus_n.alloc_addr = alloc_addr;
  assign bus_b.flush = flush;        assign bus_n.flush = flush;

  ysyx_22041412_gpr_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  ysyx_22041412_gpr_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: register contents, set of pending destinations
  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];
  int              m_cnt;

  function automatic void model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    m_cnt = 0;
  endfunction

  // Expected read for port p, given current inputs and model state
  function automatic void exp_read(input int p, input bit byp,
                                   output logic [XLEN-1:0] d, output logic b);
    int a;
    int last;
    a = int'(rd_addr[p*AW +: AW]);
    d = '0;
    b = 1'b0;
    if (rst || a == 0) return;
    d = m_regs[a];
    b = m_busy[a];
    if (byp) begin
      last = -1;
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) last = j;
      if (last >= 0) begin
        d = wr_data[last*XLEN +: XLEN];
        b = alloc_en && (int'(alloc_addr) == a);
      end
    end
  endfunction

  // Apply one clock edge's worth of architectural effect to the model
  function automatic void model_step();
    bit written [NREG];
    for (int r = 0; r < NREG; r++) written[r] = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      int a;
      a = int'(wr_addr[j*AW +: AW]);
      if (wr_en[j] && a != 0) begin
        m_regs[a] = wr_data[j*XLEN +: XLEN];
        written[a] = 1'b1;
      end
    end
    m_cnt = 0;
    for (int r = 1; r < NREG; r++) begin
      if (flush)                                  m_busy[r] = 1'b0;
      else if (alloc_en && int'(alloc_addr) == r) m_busy[r] = 1'b1;
      else if (written[r])                        m_busy[r] = 1'b0;
      m_cnt += int'(m_busy[r]);
    end
  endfunction

  task automatic idle();
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
  endtask

  // Advance one clock: model takes the edge, then settle just past it
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    for (int k = 0; k < 6; k++) begin
      rd_addr = NRD*AW'($urandom); wr_en = NWR'($urandom);
      wr_addr = NWR*AW'($urandom);
      wr_data = {$urandom, $urandom, $urandom, $urandom};
      alloc_en = 1'($urandom); alloc_addr = AW'($urandom); flush = 1'($urandom);
      #3;
      n_checks++;
      if (bus_b.rd_data !== '0 || bus_b.rd_busy !== '0 || bus_b.busy_cnt !== '0) begin
        n_fail++;
        $display("FAIL reset_b: rd_data=%h rd_busy=%b busy_cnt=%0d, required all 0",
                 bus_b.rd_data, bus_b.rd_busy, bus_b.busy_cnt);
      end
      n_checks++;
      if (bus_n.rd_data !== '0 || bus_n.rd_busy !== '0 || bus_n.busy_cnt !== '0) begin
        n_fail++;
        $display("FAIL reset_n: rd_data=%h rd_busy=%b busy_cnt=%0d, required all 0",
                 bus_n.rd_data, bus_n.rd_busy, bus_n.busy_cnt);
      end
    end
    @(posedge clk); #3;
    rst = 1'b0;
    idle();
    for (int a = 0; a < NREG; a += 2) begin
      rd_addr = {AW'(a + 1), AW'(a)};
      #1;
      n_checks++;
      if (bus_b.rd_data !== '0 || bus_n.rd_data !== '0) begin
        n_fail++;
        $display("FAIL reset_readall x%0d/x%0d: b=%h n=%h, required 0",
                 a, a + 1, bus_b.rd_data, bus_n.rd_data);
      end
    end
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    idle();
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd5; wr_data[0 +: XLEN] = 64'hDEAD_BEEF_0123_4567;
    step();
    idle();
    rd_addr[AW +: AW] = 5'd5;
    #1;
    n_checks++;
    if (bus_b.rd_data[XLEN +: XLEN] !== 64'hDEAD_BEEF_0123_4567 ||
        bus_n.rd_data[XLEN +: XLEN] !== 64'hDEAD_BEEF_0123_4567) begin
      n_fail++;
      $display("FAIL wr_rd_x5: b=%h n=%h, required deadbeef01234567",
               bus_b.rd_data[XLEN +: XLEN], bus_n.rd_data[XLEN +: XLEN]);
    end
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd0; wr_data[0 +: XLEN] = 64'h1;
    rd_addr = '0;
    #1;
    n_checks++;
    if (bus_b.rd_data[0 +: XLEN] !== '0) begin
      n_fail++;
      $display("FAIL x0_bypass: got %h, required 0", bus_b.rd_data[0 +: XLEN]);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (bus_b.rd_data[0 +: XLEN] !== '0 || bus_n.rd_data[0 +: XLEN] !== '0) begin
      n_fail++;
      $display("FAIL x0_read: b=%h n=%h, required 0",
               bus_b.rd_data[0 +: XLEN], bus_n.rd_data[0 +: XLEN]);
    end
  endtask

  task automatic test_port_conflict();
    idle();
    wr_en = 2'b11;
    wr_addr = {5'd7, 5'd7};
    wr_data = {64'h22, 64'h11};
    rd_addr[0 +: AW] = 5'd7;
    #1;
    n_checks++;
    if (bus_b.rd_data[0 +: XLEN] !== 64'h22) begin
      n_fail++;
      $display("FAIL conflict_bypass: got %h, required 22", bus_b.rd_data[0 +: XLEN]);
    end
    n_checks++;
    if (bus_n.rd_data[0 +: XLEN] !== 64'h0) begin
      n_fail++;
      $display("FAIL conflict_nobypass: got %h, required 0", bus_n.rd_data[0 +: XLEN]);
    end
    step();
    idle();
    rd_addr[0 +: AW] = 5'd7;
    #1;
    n_checks++;
    if (bus_b.rd_data[0 +: XLEN] !== 64'h22 || bus_n.rd_data[0 +: XLEN] !== 64'h22) begin
      n_fail++;
      $display("FAIL conflict_stored: b=%h n=%h, required 22",
               bus_b.rd_data[0 +: XLEN], bus_n.rd_data[0 +: XLEN]);
    end
  endtask

  task automatic test_scoreboard();
    logic [XLEN-1:0] d1, d2;
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    idle();
    alloc_en = 1'b1; alloc_addr = 5'd3;
    step();
    idle();
    rd_addr[0 +: AW] = 5'd3;
    #1;
    n_checks++;
    if (bus_b.rd_busy[0] !== 1'b1 || bus_n.rd_busy[0] !== 1'b1 || bus_b.busy_cnt !== 6'd1) begin
      n_fail++;
      $display("FAIL sb_alloc: busy b=%b n=%b cnt=%0d, required 1 1 1",
               bus_b.rd_busy[0], bus_n.rd_busy[0], bus_b.busy_cnt);
    end
    alloc_en = 1'b1; alloc_addr = 5'd3;
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd3; wr_data[0 +: XLEN] = d1;
    #1;
    n_checks++;
    if (bus_b.rd_busy[0] !== 1'b1 || bus_b.rd_data[0 +: XLEN] !== d1) begin
      n_fail++;
      $display("FAIL sb_alloc_wr_bypass: busy=%b data=%h, required 1 %h",
               bus_b.rd_busy[0], bus_b.rd_data[0 +: XLEN], d1);
    end
    step();
    idle();
    rd_addr[0 +: AW] = 5'd3;
    #1;
    n_checks++;
    if (bus_n.rd_busy[0] !== 1'b1 || bus_n.rd_data[0 +: XLEN] !== d1 || bus_n.busy_cnt !== 6'd1) begin
      n_fail++;
      $display("FAIL sb_stays_busy: busy=%b data=%h cnt=%0d, required 1 %h 1",
               bus_n.rd_busy[0], bus_n.rd_data[0 +: XLEN], bus_n.busy_cnt, d1);
    end
    wr_en = 2'b10; wr_addr[AW +: AW] = 5'd3; wr_data[XLEN +: XLEN] = d2;
    step();
    idle();
    rd_addr[0 +: AW] = 5'd3;
    #1;
    n_checks++;
    if (bus_b.rd_busy[0] !== 1'b0 || bus_b.busy_cnt !== 6'd0 || bus_b.rd_data[0 +: XLEN] !== d2) begin
      n_fail++;
      $display("FAIL sb_retire: busy=%b cnt=%0d data=%h, required 0 0 %h",
               bus_b.rd_busy[0], bus_b.busy_cnt, bus_b.rd_data[0 +: XLEN], d2);
    end
  endtask

  task automatic test_flush();
    idle();
    alloc_en = 1'b1;
    alloc_addr = 5'd1; step();
    alloc_addr = 5'd2; step();
    alloc_addr = 5'd4; step();
    idle();
    #1;
    n_checks++;
    if (bus_b.busy_cnt !== 6'd3 || bus_n.busy_cnt !== 6'd3) begin
      n_fail++;
      $display("FAIL flush_pre_cnt: b=%0d n=%0d, required 3", bus_b.busy_cnt, bus_n.busy_cnt);
    end
    flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd9;
    step();
    idle();
    rd_addr = {5'd9, 5'd2};
    #1;
    n_checks++;
    if (bus_b.busy_cnt !== 6'd0 || bus_b.rd_busy !== 2'b00 || bus_n.rd_busy !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_clear: cnt=%0d busy b=%b n=%b, required 0 00 00",
               bus_b.busy_cnt, bus_b.rd_busy, bus_n.rd_busy);
    end
    alloc_en = 1'b1; alloc_addr = 5'd6;
    step();
    alloc_en = 1'b1; alloc_addr = 5'd0;
    step();
    idle();
    #1;
    n_checks++;
    if (bus_b.busy_cnt !== 6'd1 || m_cnt != 1) begin
      n_fail++;
      $display("FAIL alloc_x0: cnt=%0d, required 1", bus_b.busy_cnt);
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] ed;
    logic            eb;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NRD; p++)
        rd_addr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      for (int j = 0; j < NWR; j++) begin
        wr_addr[j*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
        wr_data[j*XLEN +: XLEN] = {$urandom, $urandom};
      end
      wr_en = NWR'($urandom);
      alloc_en = 1'($urandom);
      alloc_addr = ($urandom_range(0, 1) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      flush = ($urandom_range(0, 15) == 0);
      #1;
      for (int p = 0; p < NRD; p++) begin
        exp_read(p, 1'b1, ed, eb);
        n_checks++;
        if (bus_b.rd_data[p*XLEN +: XLEN] !== ed || bus_b.rd_busy[p] !== eb) begin
          n_fail++;
          $display("FAIL rand_b cyc%0d port%0d: data=%h busy=%b, required %h %b",
                   c, p, bus_b.rd_data[p*XLEN +: XLEN], bus_b.rd_busy[p], ed, eb);
        end
        exp_read(p, 1'b0, ed, eb);
        n_checks++;
        if (bus_n.rd_data[p*XLEN +: XLEN] !== ed || bus_n.rd_busy[p] !== eb) begin
          n_fail++;
          $display("FAIL rand_n cyc%0d port%0d: data=%h busy=%b, required %h %b",
                   c, p, bus_n.rd_data[p*XLEN +: XLEN], bus_n.rd_busy[p], ed, eb);
        end
      end
      step();
      n_checks++;
      if (int'(bus_b.busy_cnt) != m_cnt || int'(bus_n.busy_cnt) != m_cnt) begin
        n_fail++;
        $display("FAIL rand_cnt cyc%0d: b=%0d n=%0d, required %0d",
                 c, bus_b.busy_cnt, bus_n.busy_cnt, m_cnt);
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    idle();
    flush = 1'b1; step();
    idle();
    alloc_en = 1'b1;
    alloc_addr = 5'd5; step();
    alloc_addr = 5'd6; step();
    idle();
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd10; wr_data[0 +: XLEN] = {$urandom, $urandom};
    rd_addr = {5'd6, 5'd5};
    #1;
    n_checks++;
    if (bus_b.busy_cnt !== 6'd2) begin
      n_fail++;
      $display("FAIL arst_pre_cnt: got %0d, required 2", bus_b.busy_cnt);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus_b.busy_cnt !== '0 || bus_n.busy_cnt !== '0 ||
        bus_b.rd_busy !== '0 || bus_n.rd_busy !== '0) begin
      n_fail++;
      $display("FAIL arst_clear: cnt b=%0d n=%0d busy b=%b n=%b, required 0",
               bus_b.busy_cnt, bus_n.busy_cnt, bus_b.rd_busy, bus_n.rd_busy);
    end
    model_reset();
    #2;
    rst = 1'b0;
    idle();
    step();
    rd_addr = {5'd10, 5'd7};
    #1;
    n_checks++;
    if (bus_b.rd_data !== '0 || bus_n.rd_data !== '0) begin
      n_fail++;
      $display("FAIL arst_after: b=%h n=%h, required 0", bus_b.rd_data, bus_n.rd_data);
    end
  endtask

  initial begin
    idle();
    #1;
    test_reset();
    test_write_read();
    test_port_conflict();
    test_scoreboard();
    test_flush();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
`default_nettype wire
